// File: rtl/posit_encode_sum_es3.sv
// Encodes a raw ES3 sum (sign, scale, fraction, inf, zero) into a 32-bit es=3 posit
// over a 3-stage pipeline. Define POSIT_ENCODE_RNE_EN for round-to-nearest-even, else truncation.
module posit_encode_sum_es3 #(
    parameter int NBITS    = 32,
    parameter int ES       = 3,
    parameter int FBITS_IN = 29,
    parameter int LATENCY  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FBITS_IN+11:0]  in,
    input  logic                  truncated,
    output logic [NBITS-1:0]      result,
    output logic                  done,
    output logic                  inexact
);

    localparam int MAG_W   = NBITS - 1;
    localparam int SCALE_W = 9;
    localparam int PAD_W   = 30;
    localparam int VEC_W   = 2 + ES + FBITS_IN + PAD_W;
    localparam logic [4:0] MAX_SH = 5'd30;
    localparam logic [MAG_W-1:0] MAXPOS_MAG = {MAG_W{1'b1}};
    localparam logic [MAG_W-1:0] MINPOS_MAG = {{(MAG_W-1){1'b0}}, 1'b1};

`ifdef POSIT_ENCODE_RNE_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    // Rounds a packed magnitude; never returns zero nor carries into the sign bit.
    function automatic logic [MAG_W-1:0] round_mag(
        input logic [MAG_W-1:0] mag,
        input logic             g,
        input logic             st,
        input logic             rne
    );
        logic             inc;
        logic [MAG_W:0]   sum;
        inc = rne & g & (st | mag[0]);
        sum = {1'b0, mag} + {{MAG_W{1'b0}}, inc};
        if (sum[MAG_W]) begin
            return MAXPOS_MAG;
        end else if (sum[MAG_W-1:0] == {MAG_W{1'b0}}) begin
            return MINPOS_MAG;
        end else begin
            return sum[MAG_W-1:0];
        end
    endfunction

    logic [LATENCY-1:0]        valid_sr_r;

    logic signed [SCALE_W-1:0] scale_s;
    logic signed [SCALE_W-1:0] k_s;
    logic signed [SCALE_W-1:0] sh_raw_s;
    logic [4:0]                sh_s;
    logic                      sat_hi_s;
    logic                      sat_lo_s;

    logic                      s1_sgn_r;
    logic                      s1_inf_r;
    logic                      s1_zero_r;
    logic                      s1_sat_hi_r;
    logic                      s1_sat_lo_r;
    logic                      s1_kneg_r;
    logic [4:0]                s1_sh_r;
    logic [ES-1:0]             s1_e_r;
    logic [FBITS_IN-1:0]       s1_frac_r;
    logic                      s1_trunc_r;

    logic [VEC_W-1:0]          vec_s;
    logic [VEC_W-1:0]          shifted_s;
    logic [MAG_W-1:0]          mag_s;
    logic                      g_s;
    logic                      st_s;
    logic                      sat_s;

    logic                      s2_sgn_r;
    logic                      s2_inf_r;
    logic                      s2_zero_r;
    logic                      s2_sat_r;
    logic [MAG_W-1:0]          s2_mag_r;
    logic                      s2_g_r;
    logic                      s2_st_r;

    logic [MAG_W-1:0]          mag_f_s;
    logic [NBITS-1:0]          res_s;
    logic                      inx_s;

    // Valid shift register; an X on start never launches an item.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr_r <= {LATENCY{1'b0}};
        end else begin
            valid_sr_r <= {valid_sr_r[LATENCY-2:0], (start === 1'b1)};
        end
    end

    assign done = valid_sr_r[LATENCY-1];

    // Decode: regime index, exponent, shift amount and saturation range.
    always_comb begin
        scale_s  = $signed(in[FBITS_IN+10:FBITS_IN+2]);
        k_s      = scale_s >>> 3;
        sat_hi_s = (scale_s > 9'sd239);
        sat_lo_s = (scale_s < -9'sd240);
        // ~k equals -k-1: the run of zeros minus the one already in the prefix
        if (k_s >= 9'sd0) begin
            sh_raw_s = k_s;
        end else begin
            sh_raw_s = ~k_s;
        end
        if (sh_raw_s > 9'sd30) begin
            sh_s = MAX_SH;
        end else begin
            sh_s = sh_raw_s[4:0];
        end
    end

    // Stage 1 data capture.
    always_ff @(posedge clk) begin
        if (start === 1'b1) begin
            s1_sgn_r    <= in[FBITS_IN+11];
            s1_inf_r    <= in[1];
            s1_zero_r   <= in[0];
            s1_sat_hi_r <= sat_hi_s;
            s1_sat_lo_r <= sat_lo_s;
            s1_kneg_r   <= k_s[SCALE_W-1];
            s1_sh_r     <= sh_s;
            s1_e_r      <= scale_s[ES-1:0];
            s1_frac_r   <= in[FBITS_IN+1:2];
            s1_trunc_r  <= truncated;
        end
    end

    // Pack: prefix 10/01 is arithmetic-shifted so its top bit fills the regime run.
    always_comb begin
        vec_s     = {~s1_kneg_r, s1_kneg_r, s1_e_r, s1_frac_r, {PAD_W{1'b0}}};
        shifted_s = $unsigned($signed(vec_s) >>> s1_sh_r);
        if (s1_sat_hi_r) begin
            mag_s = MAXPOS_MAG;
            g_s   = 1'b0;
            st_s  = 1'b0;
            sat_s = 1'b1;
        end else if (s1_sat_lo_r) begin
            mag_s = MINPOS_MAG;
            g_s   = 1'b0;
            st_s  = 1'b0;
            sat_s = 1'b1;
        end else begin
            mag_s = shifted_s[VEC_W-1 -: MAG_W];
            g_s   = shifted_s[VEC_W-1-MAG_W];
            st_s  = (|shifted_s[VEC_W-2-MAG_W:0]) | s1_trunc_r;
            sat_s = 1'b0;
        end
    end

    // Stage 2 data capture.
    always_ff @(posedge clk) begin
        if (valid_sr_r[0]) begin
            s2_sgn_r  <= s1_sgn_r;
            s2_inf_r  <= s1_inf_r;
            s2_zero_r <= s1_zero_r;
            s2_sat_r  <= sat_s;
            s2_mag_r  <= mag_s;
            s2_g_r    <= g_s;
            s2_st_r   <= st_s;
        end
    end

    // Round, apply sign, and resolve specials (inf wins over zero).
    always_comb begin
        mag_f_s = s2_mag_r;
        res_s   = {NBITS{1'b0}};
        inx_s   = 1'b0;
        if (s2_inf_r) begin
            res_s = {1'b1, {(NBITS-1){1'b0}}};
            inx_s = 1'b0;
        end else if (s2_zero_r) begin
            res_s = {NBITS{1'b0}};
            inx_s = 1'b0;
        end else begin
            if (s2_sat_r) begin
                mag_f_s = s2_mag_r;
            end else begin
                mag_f_s = round_mag(s2_mag_r, s2_g_r, s2_st_r, RNE_EN);
            end
            if (s2_sgn_r) begin
                res_s = ~{1'b0, mag_f_s} + {{(NBITS-1){1'b0}}, 1'b1};
            end else begin
                res_s = {1'b0, mag_f_s};
            end
            inx_s = s2_g_r | s2_st_r | s2_sat_r;
        end
    end

    // Output registers hold their last value between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            result  <= {NBITS{1'b0}};
            inexact <= 1'b0;
        end else if (valid_sr_r[1]) begin
            result  <= res_s;
            inexact <= inx_s;
        end
    end

endmodule

// File: tb/tb_posit_encode_sum_es3.sv
// Directed-vector bench for posit_encode_sum_es3; expectations are hand-computed posit encodings.
module tb_posit_encode_sum_es3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [40:0] in;
    logic        truncated;
    logic [31:0] result;
    logic        done;
    logic        inexact;

    always #5 clk = ~clk;

    posit_encode_sum_es3 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in        (in),
        .truncated (truncated),
        .result    (result),
        .done      (done),
        .inexact   (inexact)
    );

`ifdef POSIT_ENCODE_RNE_EN
    localparam logic [31:0] EXP_R5    = 32'h4000_0001;
    localparam logic [31:0] EXP_RTR   = 32'h4000_0001;
    localparam logic [31:0] EXP_RODD  = 32'h4000_0002;
    localparam logic [31:0] EXP_S239  = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] EXP_R5    = 32'h4000_0000;
    localparam logic [31:0] EXP_RTR   = 32'h4000_0000;
    localparam logic [31:0] EXP_RODD  = 32'h4000_0001;
    localparam logic [31:0] EXP_S239  = 32'h7FFF_FFFE;
`endif

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        inx;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] last_res = 32'h0;
    logic        last_inx = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: checks each result on its due cycle, and idle/hold behaviour otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check_val({exp_q[0].name, "_done"}, {31'd0, done}, 32'd1);
                check_val({exp_q[0].name, "_res"}, result, exp_q[0].res);
                check_val({exp_q[0].name, "_inx"}, {31'd0, inexact}, {31'd0, exp_q[0].inx});
                last_res = exp_q[0].res;
                last_inx = exp_q[0].inx;
                void'(exp_q.pop_front());
            end else begin
                check_val("idle_done", {31'd0, done}, 32'd0);
                check_val("hold_res", result, last_res);
                check_val("hold_inx", {31'd0, inexact}, {31'd0, last_inx});
            end
        end
    end

    task automatic send(input string name, input bit sgn, input int scale, input logic [28:0] frac,
                        input bit inf, input bit zero, input bit trunc,
                        input logic [31:0] er, input bit ei);
        logic [8:0] sc;
        exp_t       e;
        sc = scale[8:0];
        @(negedge clk);
        in        = {sgn, sc, frac, inf, zero};
        truncated = trunc;
        start     = 1'b1;
        e.name = name;
        e.res  = er;
        e.inx  = ei;
        e.due  = cyc + 3;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in        = 41'd0;
        truncated = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_result", result, 32'h0);
        check_val("rst_inexact", {31'd0, inexact}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        //   name        sgn scale frac          inf zero trn  result         inx
        send("one",       0,    0, 29'h0,        0,  0,   0, 32'h4000_0000, 0);
        send("s1",        0,    1, 29'h0,        0,  0,   0, 32'h4400_0000, 0);
        send("s8",        0,    8, 29'h0,        0,  0,   0, 32'h6000_0000, 0);
        send("sm8",       0,   -8, 29'h0,        0,  0,   0, 32'h2000_0000, 0);
        send("minus_one", 1,    0, 29'h0,        0,  0,   0, 32'hC000_0000, 0);
        send("tie",       0,    0, 29'h4,        0,  0,   0, 32'h4000_0000, 1);
        send("r5",        0,    0, 29'h5,        0,  0,   0, EXP_R5,        1);
        send("tie_trunc", 0,    0, 29'h4,        0,  0,   1, EXP_RTR,       1);
        send("tie_odd",   0,    0, 29'hC,        0,  0,   0, EXP_RODD,      1);
        send("frac_pat",  0,    0, 29'h1234_5678, 0, 0,   0, 32'h4246_8ACF, 0);
        send("s5_pat",    0,    5, 29'h1234_5678, 0, 0,   0, 32'h5646_8ACF, 0);
        send("neg_sm1",   1,   -1, 29'h0,        0,  0,   0, 32'hC400_0000, 0);
        send("s232",      0,  232, 29'h0,        0,  0,   0, 32'h7FFF_FFFE, 0);
        send("s239",      0,  239, 29'h0,        0,  0,   0, EXP_S239,      1);
        send("s240",      0,  240, 29'h0,        0,  0,   0, 32'h7FFF_FFFF, 1);
        send("sm240",     0, -240, 29'h0,        0,  0,   0, 32'h0000_0001, 0);
        send("sm241",     0, -241, 29'h0,        0,  0,   0, 32'h0000_0001, 1);
        send("inf_zero",  0,    0, 29'h0,        1,  1,   0, 32'h8000_0000, 0);
        send("inf_only",  1,    3, 29'h7,        1,  0,   1, 32'h8000_0000, 0);
        send("zero_only", 1,    3, 29'h7,        0,  1,   1, 32'h0000_0000, 0);
        send("sat_hi",    0,  250, 29'h0,        0,  0,   0, 32'h7FFF_FFFF, 1);
        send("sat_lo",    0, -250, 29'h0,        0,  0,   0, 32'h0000_0001, 1);
        send("sat_hi_n",  1,  250, 29'h0,        0,  0,   0, 32'h8000_0001, 1);
        send("sat_lo_n",  1, -250, 29'h0,        0,  0,   0, 32'hFFFF_FFFF, 1);

        @(negedge clk);
        start = 1'bx;
        in    = 41'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check_val("drain", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);

        // Reset one cycle after start: the item must vanish and outputs clear.
        mon_en    = 1'b0;
        in        = {1'b0, 9'd8, 29'd0, 2'b00};
        truncated = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_result", result, 32'h0);
        check_val("midrst_inexact", {31'd0, inexact}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        reset    = 1'b0;
        last_res = 32'h0;
        last_inx = 1'b0;
        mon_en   = 1'b1;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/posit_encode_sum_es3.md
Name: posit_encode_sum_es3

Overview:
- Output-side counterpart of the raw ES3 adder.
- Takes a raw serialized sum (sign, scale, hidden-less fraction, inf, zero) and encodes it into a standard 32-bit posit with es=3.
- Encoding covers regime/exponent packing, rounding, saturation and two's-complement sign handling.
- Fully pipelined with start/done qualifiers; sits directly after the adder or accumulator raw path and feeds posit-format writeback.

Parameters:
- NBITS, 32, encoded posit width (only 32 supported).
- ES, 3, exponent field width (fixed).
- FBITS_IN, 29, raw fraction width, equal to ABITS.
- LATENCY, 3, start-to-done pipeline depth (informational, not configurable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  input qualifier; X is treated as 0.
- in  input  POSIT_SERIALIZED_WIDTH_SUM_ES3 (41)  raw sum. Field layout:
  - [40] sgn
  - [39:31] scale, 9-bit signed
  - [30:2] fraction, hidden bit excluded
  - [1] inf
  - [0] zero
- truncated  input  1  sticky from the upstream adder; ORed into rounding sticky.
- result  output  32  encoded posit.
- done  output  1  result qualifier; high exactly LATENCY cycles after start.
- inexact  output  1  any nonzero discarded bit, truncated set, or saturation occurred.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: done=0, result=32'h0, inexact=0. All stage valid bits are cleared. Data registers need not be reset.
- Reset asserted mid-operation: in-flight items are discarded; no done pulse for them.
- Pipeline: no backpressure. A new start is accepted every cycle. Results leave in order, exactly 3 cycles after their start.
- Stage 1, decode (registers captured in, start, truncated):
  - k = scale >>> 3 (arithmetic shift); e = scale[2:0].
  - Special precedence is inf > zero > normal.
  - inf: result 32'h80000000, inexact=0.
  - zero (and not inf): result 32'h00000000, inexact=0.
- Stage 2, pack:
  - Regime: if k >= 0, (k+1) ones then a zero; if k < 0, (-k) zeros then a one.
  - Form the 63-bit word {regime, e, fraction, zero padding}.
  - Shift by run length so the unsigned magnitude occupies bits [30:0].
  - Keep guard bit G (first discarded bit) and sticky S (OR of remaining discarded bits | truncated).
- Saturation:
  - scale > 239 gives magnitude 31'h7FFFFFFF.
  - scale < -240 gives magnitude 31'h00000001.
  - inexact=1 in both cases. Rounding is bypassed.
- Stage 3, round and sign:
  - Round to nearest even: increment when G & (S | lsb).
  - Magnitude never rounds to 0 (clamp to 1) or into bit 31 (clamp to 31'h7FFFFFFF).
  - sgn=1: result = two's complement of {1'b0, magnitude}.
  - inexact = G | S | saturation.
- Arithmetic rules:
  - scale is interpreted signed, range -256..255.
  - The regime run length is capped at 31 bits.
  - Shifter widths are sized so that no discarded bit is lost from the sticky.
- Idle outputs: result and inexact hold their last value while done=0.

Optional Feature:
- Macro: POSIT_ENCODE_RNE_EN.
- Defined: round to nearest even as above.
- Undefined: truncate the magnitude, i.e. no increment.
  - A magnitude of 0 is still clamped to 1 (minpos); saturation is unchanged.
  - inexact is still computed identically.
- Latency is 3 in both builds.

Test Plan:
- One: sgn=0, scale=0, frac=0 -> result 32'h40000000, inexact=0.
- Minus one: sgn=1, same value -> result 32'hC0000000.
- Scale sweep, frac=0, one start per cycle:
  - scale=1 -> 32'h44000000
  - scale=8 -> 32'h60000000
  - scale=-8 -> 32'h20000000
  - Expect four consecutive done pulses in order.
- Rounding at scale=0:
  - frac=29'h4 (tie) -> 32'h40000000, inexact=1.
  - frac=29'h5 -> 32'h40000001.
  - frac=29'h4 with truncated=1 -> 32'h40000001.
  - Without POSIT_ENCODE_RNE_EN, all three -> 32'h40000000.
- Saturation:
  - scale=250 -> 32'h7FFFFFFF, inexact=1.
  - scale=-250 -> 32'h00000001, inexact=1.
  - same with sgn=1 -> 32'h80000001 and 32'hFFFFFFFF.
- Specials and reset:
  - inf=1, zero=1 -> 32'h80000000.
  - zero only -> 32'h0.
  - Assert reset one cycle after start -> no done pulse; outputs read 0 the cycle after reset.
